// File: rtl/cipher_stream_if.sv
// ============================================================================
// cipher_stream_if : word-stream key/block loader and result port for a
//                    combinational AES cipher. Optional: CIPHER_OVERLAP_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cipher_stream_if #(
  parameter int NK          = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_word,
  input  logic              i_word_valid,
  input  logic              i_word_is_key,
  output logic              o_word_ready,
  output logic [32*NK-1:0]  o_cipher_key,
  output logic [127:0]      o_cipher_data,
  input  logic [127:0]      i_cipher_result,
  output logic [127:0]      o_result,
  output logic              o_result_valid,
  input  logic              i_result_ready,
  output logic              o_busy
);

  localparam logic [1:0] c_st_load    = 2'd0;
  localparam logic [1:0] c_st_compute = 2'd1;
  localparam logic [1:0] c_st_out     = 2'd2;
  localparam int         c_key_w      = 32 * NK;

  logic [1:0]         r_state;
  logic [c_key_w-1:0] r_key;
  logic [127:0]       r_data;
  logic [3:0]         r_key_cnt;
  logic [2:0]         r_data_cnt;
  logic               r_key_ok;
  logic [7:0]         r_wait_cnt;
  logic [127:0]       r_result;
  logic               r_result_valid;

  logic w_load_ready;
  logic w_key_accept;
  logic w_data_accept;
  logic w_block_ready;
  logic w_capture;

  // Data words stall (rather than drop) until a complete key is present.
  always_comb begin
    w_load_ready = i_word_is_key ? 1'b1 : (r_key_ok && (r_data_cnt < 3'd4));
  end

  always_comb begin
    o_word_ready = 1'b0;
    case (r_state)
      c_st_load: o_word_ready = w_load_ready;
`ifdef CIPHER_OVERLAP_EN
      c_st_out:  o_word_ready = w_load_ready;
`endif
      default:   o_word_ready = 1'b0;
    endcase
  end

  assign w_key_accept  = i_word_valid && o_word_ready && i_word_is_key;
  assign w_data_accept = i_word_valid && o_word_ready && !i_word_is_key;
  assign w_block_ready = (r_data_cnt == 3'd4) && r_key_ok;
  assign w_capture     = (r_state == c_st_compute) && (r_wait_cnt == 8'd0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_key      <= '0;
      r_key_cnt  <= 4'd0;
      r_key_ok   <= 1'b0;
      r_data     <= '0;
      r_data_cnt <= 3'd0;
    end else begin
      if (w_key_accept) begin
        r_key <= {r_key[c_key_w-33:0], i_word};
        if (r_key_cnt == 4'(NK - 1)) begin
          r_key_cnt <= 4'd0;
          r_key_ok  <= 1'b1;
        end else begin
          r_key_cnt <= r_key_cnt + 4'd1;
          // First word of a fresh key invalidates the old one.
          if (r_key_cnt == 4'd0) begin
            r_key_ok <= 1'b0;
          end
        end
      end
      if (w_data_accept) begin
        r_data     <= {r_data[95:0], i_word};
        r_data_cnt <= r_data_cnt + 3'd1;
      end else if (w_capture) begin
        r_data_cnt <= 3'd0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= c_st_load;
      r_wait_cnt     <= 8'd0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      case (r_state)
        c_st_load: begin
          if (w_block_ready) begin
            r_state    <= c_st_compute;
            r_wait_cnt <= 8'(WAIT_CYCLES - 1);
          end
        end
        c_st_compute: begin
          if (r_wait_cnt == 8'd0) begin
            r_result       <= i_cipher_result;
            r_result_valid <= 1'b1;
            r_state        <= c_st_out;
          end else begin
            r_wait_cnt <= r_wait_cnt - 8'd1;
          end
        end
        c_st_out: begin
          if (i_result_ready) begin
            r_result_valid <= 1'b0;
`ifdef CIPHER_OVERLAP_EN
            // A preloaded block gets one extra settle cycle so the
            // back-to-back period equals the LOAD-path period.
            if (w_block_ready) begin
              r_state    <= c_st_compute;
              r_wait_cnt <= 8'(WAIT_CYCLES);
            end else begin
              r_state <= c_st_load;
            end
`else
            r_state <= c_st_load;
`endif
          end
        end
        default: r_state <= c_st_load;
      endcase
    end
  end

  assign o_cipher_key   = r_key;
  assign o_cipher_data  = r_data;
  assign o_result       = r_result;
  assign o_result_valid = r_result_valid;
  assign o_busy         = (r_state != c_st_load);

endmodule

`default_nettype wire

// File: tb/tb_cipher_stream_if.sv
// ============================================================================
// tb_cipher_stream_if : self-checking bench with a behavioural AES-128 cipher
//                       and a cycle model of the stream interface.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cipher_stream_if;

  localparam int NK = 4;
  localparam int W  = 1;
`ifdef CIPHER_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif
  localparam logic [127:0] C_FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         i_rst;
  logic [31:0]  i_word;
  logic         i_word_valid;
  logic         i_word_is_key;
  logic         o_word_ready;
  logic [127:0] o_cipher_key;
  logic [127:0] o_cipher_data;
  logic [127:0] cipher_result;
  logic [127:0] o_result;
  logic         o_result_valid;
  logic         i_result_ready;
  logic         o_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cipher_stream_if #(.NK(NK), .WAIT_CYCLES(W)) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_word         (i_word),
    .i_word_valid   (i_word_valid),
    .i_word_is_key  (i_word_is_key),
    .o_word_ready   (o_word_ready),
    .o_cipher_key   (o_cipher_key),
    .o_cipher_data  (o_cipher_data),
    .i_cipher_result(cipher_result),
    .o_result       (o_result),
    .o_result_valid (o_result_valid),
    .i_result_ready (i_result_ready),
    .o_busy         (o_busy)
  );

  // ---------------- behavioural AES-128 ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] p;
    logic [7:0] e;
    r = 8'h01;
    p = b;
    e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes128(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] out;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox(s[(i%4) + 4*(((i/4) + (i%4)) % 4)]);
      for (int c = 0; c < 4; c++) begin
        if (r != 10) begin
          s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end else begin
          for (int k = 0; k < 4; k++) s[4*c+k] = t[4*c+k];
        end
      end
      for (int i = 0; i < 16; i++) s[i] ^= w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
    return out;
  endfunction

  // The attached cipher.
  always_comb cipher_result = aes128(o_cipher_key, o_cipher_data);

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // ---------------- interface model ----------------
  logic [127:0] m_key, m_data, m_result;
  int           m_kcnt, m_dcnt, m_wait;
  bit           m_key_ok, m_valid, m_init = 1'b0;

  always @(negedge clk) begin : compare
    logic exp_ready, exp_busy, ld;
    logic [127:0] n_key, n_data, n_result;
    int n_kcnt, n_dcnt, n_wait;
    bit n_key_ok, n_valid;
    exp_busy  = (m_wait > 0) || m_valid;
    ld        = i_word_is_key ? 1'b1 : (m_key_ok && m_dcnt < 4);
    exp_ready = ld && (!exp_busy || (OVL && m_valid));
    if (m_init) begin
      check("word_ready",   {127'd0, o_word_ready},   {127'd0, exp_ready});
      check("busy",         {127'd0, o_busy},         {127'd0, exp_busy});
      check("result_valid", {127'd0, o_result_valid}, {127'd0, m_valid});
      check("result",       o_result,      m_result);
      check("cipher_key",   o_cipher_key,  m_key);
      check("cipher_data",  o_cipher_data, m_data);
    end
    if (i_rst) begin
      m_key = '0; m_data = '0; m_result = '0;
      m_kcnt = 0; m_dcnt = 0; m_wait = -1; m_key_ok = 0; m_valid = 0;
      m_init = 1'b1;
    end else if (m_init) begin
      n_key = m_key; n_data = m_data; n_result = m_result;
      n_kcnt = m_kcnt; n_dcnt = m_dcnt; n_wait = m_wait;
      n_key_ok = m_key_ok; n_valid = m_valid;
      // m_wait = edges left until the cipher output is captured.
      if (m_wait > 0) begin
        if (m_wait == 1) begin
          n_result = aes128(m_key, m_data);
          n_valid  = 1'b1;
          n_dcnt   = 0;
          n_wait   = -1;
        end else begin
          n_wait = m_wait - 1;
        end
      end else if (m_valid) begin
        if (i_result_ready) begin
          n_valid = 1'b0;
          if (OVL && m_dcnt == 4 && m_key_ok) n_wait = W + 1;
        end
      end else if (m_dcnt == 4 && m_key_ok) begin
        n_wait = W;
      end
      if (i_word_valid && exp_ready) begin
        if (i_word_is_key) begin
          n_key = {m_key[95:0], i_word};
          if (m_kcnt == NK - 1) begin
            n_kcnt = 0; n_key_ok = 1'b1;
          end else begin
            n_kcnt = m_kcnt + 1;
            if (m_kcnt == 0) n_key_ok = 1'b0;
          end
        end else begin
          n_data = {m_data[95:0], i_word};
          n_dcnt = m_dcnt + 1;
        end
      end
      m_key = n_key; m_data = n_data; m_result = n_result;
      m_kcnt = n_kcnt; m_dcnt = n_dcnt; m_wait = n_wait;
      m_key_ok = n_key_ok; m_valid = n_valid;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_word(input logic [31:0] w, input logic k);
    int n;
    @(posedge clk); #1;
    i_word = w; i_word_is_key = k; i_word_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!o_word_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!o_word_ready) check("word_accept_timeout", 128'd0, 128'd1);
    @(posedge clk); #1;
    i_word_valid = 1'b0;
  endtask

  task automatic send_key();
    for (int i = 0; i < 4; i++) send_word(C_FIPS_KEY[127-32*i -: 32], 1'b1);
  endtask

  task automatic send_data(input int nwords);
    for (int i = 0; i < nwords; i++) send_word(C_FIPS_PT[127-32*i -: 32], 1'b0);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_result_valid && n < 50);
    if (!o_result_valid) check("result_valid_timeout", 128'd0, 128'd1);
  endtask

  initial begin : stim
    int n;
    logic busy_seen;
    i_rst = 1'b1; i_word = '0; i_word_valid = 1'b0; i_word_is_key = 1'b0; i_result_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    check("reset_result", o_result, 128'd0);
    check("reset_valid",  {127'd0, o_result_valid}, 128'd0);
    check("reset_key",    o_cipher_key, 128'd0);
    check("model_fips",   aes128(C_FIPS_KEY, C_FIPS_PT), C_FIPS_CT);

    // Data before key: stalls, nothing accepted.
    @(posedge clk); #1;
    i_word = 32'h00112233; i_word_is_key = 1'b0; i_word_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("nokey_stall", {127'd0, o_word_ready}, 128'd0);
    end
    @(posedge clk); #1 i_word_valid = 1'b0;
    check("nokey_data_cnt_untouched", o_cipher_data, 128'd0);

    // Basic block, latency and one-cycle valid.
    send_key();
    send_data(4);
    wait_valid(n);
    check("basic_latency", n, W + 2);
    check("basic_ct", o_result, C_FIPS_CT);
    @(negedge clk);
    check("basic_valid_one_cycle", {127'd0, o_result_valid}, 128'd0);

    // Key persistence.
    send_data(4);
    wait_valid(n);
    check("persist_ct", o_result, C_FIPS_CT);
    check("persist_key", o_cipher_key, C_FIPS_KEY);

    // Backpressure.
    @(posedge clk); #1 i_result_ready = 1'b0;
    send_data(4);
    wait_valid(n);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_held", {127'd0, o_result_valid}, 128'd1);
      check("bp_result_stable", o_result, C_FIPS_CT);
      if (!OVL) check("bp_word_ready_low", {127'd0, o_word_ready}, 128'd0);
    end
    @(posedge clk); #1 i_result_ready = 1'b1;
    @(negedge clk);
    check("bp_release_hold", {127'd0, o_result_valid}, 128'd1);
    @(negedge clk);
    check("bp_release_drop", {127'd0, o_result_valid}, 128'd0);

    // Reset mid-block.
    send_data(2);
    @(posedge clk); #1 i_rst = 1'b1;
    @(posedge clk); #1 i_rst = 1'b0;
    @(negedge clk);
    check("midrst_key",   o_cipher_key, 128'd0);
    check("midrst_data",  o_cipher_data, 128'd0);
    check("midrst_result", o_result, 128'd0);
    check("midrst_busy",  {127'd0, o_busy}, 128'd0);
    @(posedge clk); #1;
    i_word = 32'h00112233; i_word_is_key = 1'b0; i_word_valid = 1'b1;
    @(negedge clk);
    check("midrst_key_ok_cleared", {127'd0, o_word_ready}, 128'd0);
    @(posedge clk); #1 i_word_valid = 1'b0;
    send_key();
    send_data(4);
    wait_valid(n);
    check("midrst_reload_ct", o_result, C_FIPS_CT);

`ifdef CIPHER_OVERLAP_EN
    // Next block assembled while the result waits.
    @(posedge clk); #1 i_result_ready = 1'b0;
    send_data(4);
    wait_valid(n);
    send_data(4);
    @(negedge clk);
    check("ovl_result_stable", o_result, C_FIPS_CT);
    check("ovl_valid_held", {127'd0, o_result_valid}, 128'd1);
    @(posedge clk); #1 i_result_ready = 1'b1;
    @(negedge clk);
    n = 0;
    busy_seen = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) busy_seen = o_busy;
    end while (!o_result_valid && n < 50);
    check("ovl_direct_compute", {127'd0, busy_seen}, 128'd1);
    check("ovl_latency", n, W + 2);
    check("ovl_ct", o_result, C_FIPS_CT);
`else
    busy_seen = 1'b0;
`endif

    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
